// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder: phase encodings,
// direction constants and the phase-step classification helper.
package qdec_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        P00 = PH_00,
        P10 = PH_10,
        P11 = PH_11,
        P01 = PH_01
    } phase_e;

    typedef struct packed {
        logic valid;
        logic illegal;
        logic up;
    } step_t;

    // Position of a phase along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_pos(input logic [1:0] ph);
        logic [1:0] pos;
        case (ph)
            PH_00:   pos = 2'd0;
            PH_10:   pos = 2'd1;
            PH_11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    // Classifies a phase change: one position forward is up, one back is
    // down, two positions apart is an illegal two-bit jump.
    function automatic step_t qdec_step(input logic [1:0] prev, input logic [1:0] next);
        step_t      res;
        logic [1:0] delta;
        delta       = phase_pos(next) - phase_pos(prev);
        res.valid   = (delta == 2'd1) || (delta == 2'd3);
        res.illegal = (delta == 2'd2);
        res.up      = (delta == 2'd1);
        return res;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Input synchronizer plus stability filter for the A/B encoder phases.
// Emits the accepted phase and a one-cycle event whenever it changes.
module qdec_sync_filter
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       force_accept,
    output logic [1:0] phase,
    output logic       event_pulse
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             synced;
    logic [1:0]             prev_pair;
    logic [CW-1:0]          stab_cnt;
    logic [CW-1:0]          stab_nxt;
    logic                   accept;

    assign synced = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // Next stability count, plus the accept decision; a forced accept only
    // fires on the cycle the count first saturates so it cannot repeat.
    always_comb begin
        stab_nxt = stab_cnt;
        if (synced != prev_pair) begin
            stab_nxt = '0;
        end else if (stab_cnt != FULL) begin
            stab_nxt = stab_cnt + CW'(1);
        end
        accept = (stab_nxt == FULL) &&
                 ((synced != phase) || (force_accept && (stab_cnt != FULL)));
    end

    // Synchronizer shift, stability counter and accepted-phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a      <= '0;
            sync_b      <= '0;
            prev_pair   <= PH_00;
            stab_cnt    <= '0;
            phase       <= PH_00;
            event_pulse <= 1'b0;
        end else begin
            sync_a      <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b      <= {sync_b[SYNC_STAGES-2:0], enc_b};
            prev_pair   <= synced;
            stab_cnt    <= stab_nxt;
            event_pulse <= accept;
            if (accept) begin
                phase <= synced;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: phase FSM, wrapping position counter,
// sticky illegal-jump flag and the post-reset init handling.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    logic [1:0] acc_phase;
    logic       evt;
    logic       init;
    phase_e     state;
    step_t      step_res;

    qdec_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk          (clk),
        .rst          (rst),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .force_accept (init),
        .phase        (acc_phase),
        .event_pulse  (evt)
    );

    // Classify the move from the current FSM state to the newly accepted phase.
    always_comb begin
        step_res = qdec_step(state, acc_phase);
    end

    // Phase FSM with counter, direction, step pulse and sticky error; clr
    // overrides the count and suppresses the step while the FSM keeps tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= P00;
            init  <= 1'b1;
            count <= '0;
            dir   <= DIR_DN;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            if (evt) begin
                state <= phase_e'(acc_phase);
                if (init) begin
                    init <= 1'b0;
                end else if (step_res.illegal) begin
                    err <= 1'b1;
                end else if (step_res.valid && !clr) begin
                    step  <= 1'b1;
                    dir   <= step_res.up ? DIR_UP : DIR_DN;
                    count <= step_res.up ? count + WIDTH'(1) : count - WIDTH'(1);
                end
            end
            if (clr) begin
                count <= '0;
            end
        end
    end

endmodule
